// File: rtl/wb_stage_param.sv
// wb_stage_param: MIPS32 writeback stage.
// Retires one MEM/WB instruction per cycle under valid/ready and drives a
// registered register-file write port. Adds sub-word load extraction, r0 write
// suppression, a HALTED/RUN state machine with resume, a retired-instruction
// counter and a sticky error flag.
//
// state  | meaning
// -------+---------------------------------------------------------------
// RUN    | accepting instructions, in_ready=1
// HALTED | a HALT retired; nothing accepted until resume is seen
module wb_stage_param #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int CNT_W  = 32,
   parameter int LANE_W = $clog2(DATA_W/8)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_flush,
   input  logic [2:0]        in_type,
   input  logic [31:0]       in_ir,
   input  logic [DATA_W-1:0] in_aluout,
   input  logic [DATA_W-1:0] in_lmd,
   input  logic [1:0]        in_ld_size,
   input  logic              in_ld_signed,
   input  logic [LANE_W-1:0] in_addr_lo,
   input  logic              resume,
   output logic              wb_regwrite,
   output logic [REG_AW-1:0] wb_rd,
   output logic [DATA_W-1:0] wb_data,
   output logic              halted,
   output logic [CNT_W-1:0]  retired_cnt,
   output logic              err
);

   typedef enum logic {
      RUN    = 1'b0,
      HALTED = 1'b1
   } state_t;

   localparam logic [2:0] T_RR     = 3'b000;
   localparam logic [2:0] T_RM     = 3'b001;
   localparam logic [2:0] T_LOAD   = 3'b010;
   localparam logic [2:0] T_STORE  = 3'b011;
   localparam logic [2:0] T_BRANCH = 3'b100;
   localparam logic [2:0] T_HALT   = 3'b101;

   localparam logic [1:0] SZ_WORD = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_BYTE = 2'b10;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t              state_q, state_d;
   logic                wb_regwrite_q, wb_regwrite_d;
   logic [REG_AW-1:0]   wb_rd_q, wb_rd_d;
   logic [DATA_W-1:0]   wb_data_q, wb_data_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                err_q, err_d;

   logic                accept;
   logic [REG_AW-1:0]   rd_rr;
   logic [REG_AW-1:0]   rd_rm;
   logic [7:0]          byte_lane;
   logic [15:0]         half_lane;
   logic [DATA_W-1:0]   byte_ext;
   logic [DATA_W-1:0]   half_ext;
   logic                unused_ir;

   assign in_ready = (state_q == RUN);
   assign accept   = in_valid && in_ready;

   // Destination fields come from the low REG_AW bits of rd/rt in the IR;
   // the remaining IR bits carry nothing this stage needs.
   assign rd_rr     = in_ir[11 +: REG_AW];
   assign rd_rm     = in_ir[16 +: REG_AW];
   assign unused_ir = ^in_ir;

   // Lane selection: bytes by full offset, halves by offset with bit 0 dropped
   assign byte_lane = in_lmd[{in_addr_lo, 3'b000} +: 8];
   assign half_lane = in_lmd[{in_addr_lo[LANE_W-1:1], 4'b0000} +: 16];
   assign byte_ext  = {{(DATA_W-8){in_ld_signed & byte_lane[7]}}, byte_lane};
   assign half_ext  = {{(DATA_W-16){in_ld_signed & half_lane[15]}}, half_lane};

   // Next-state decode: writeback port defaults to idle every cycle
   always_comb begin
      logic              wr;
      logic [REG_AW-1:0] rd;
      logic [DATA_W-1:0] data;

      wr            = 1'b0;
      rd            = '0;
      data          = '0;
      state_d       = state_q;
      cnt_d         = cnt_q;
      err_d         = err_q;
      wb_regwrite_d = 1'b0;
      wb_rd_d       = '0;
      wb_data_d     = '0;

      case (state_q)
         RUN: begin
            if (accept && !in_flush) begin
               case (in_type)
                  T_RR: begin
                     wr   = 1'b1;
                     rd   = rd_rr;
                     data = in_aluout;
                  end
                  T_RM: begin
                     wr   = 1'b1;
                     rd   = rd_rm;
                     data = in_aluout;
                  end
                  T_LOAD: begin
                     rd = rd_rm;
                     case (in_ld_size)
                        SZ_WORD: begin
                           wr   = 1'b1;
                           data = in_lmd;
                        end
                        SZ_HALF: begin
                           if (in_addr_lo[0]) begin
                              err_d = 1'b1;
                           end else begin
                              wr   = 1'b1;
                              data = half_ext;
                           end
                        end
                        SZ_BYTE: begin
                           wr   = 1'b1;
                           data = byte_ext;
                        end
                        default: err_d = 1'b1;
                     endcase
                  end
                  T_STORE, T_BRANCH: ;
                  T_HALT: state_d = HALTED;
                  default: err_d = 1'b1;
               endcase

               // Illegal types are the only legal-path exception to counting
               if (in_type <= T_HALT) begin
                  cnt_d = cnt_q + CNT_ONE;
               end

               // r0 is hardwired; its writes vanish entirely
               if (wr && (rd != '0)) begin
                  wb_regwrite_d = 1'b1;
                  wb_rd_d       = rd;
                  wb_data_d     = data;
               end
            end
         end
         HALTED: begin
            if (resume) begin
               state_d = RUN;
            end
         end
         default: state_d = RUN;
      endcase
   end

   // State, writeback port, counter and error flag registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= RUN;
         wb_regwrite_q <= 1'b0;
         wb_rd_q       <= '0;
         wb_data_q     <= '0;
         cnt_q         <= '0;
         err_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         wb_regwrite_q <= wb_regwrite_d;
         wb_rd_q       <= wb_rd_d;
         wb_data_q     <= wb_data_d;
         cnt_q         <= cnt_d;
         err_q         <= err_d;
      end
   end

   assign wb_regwrite = wb_regwrite_q;
   assign wb_rd       = wb_rd_q;
   assign wb_data     = wb_data_q;
   assign halted      = (state_q == HALTED);
   assign retired_cnt = cnt_q;
   assign err         = err_q;

endmodule
